// File: rtl/fft_out_serializer_pkg.sv
// Shared FFT constants: frame length, lanes per beat and the sample-index width.
package fft_out_serializer_pkg;

  localparam int unsigned FFT_N     = 128;
  localparam int unsigned FFT_LANES = 4;

  typedef enum logic [1:0] {
    LANE_0_UP   = 2'd0,
    LANE_0_DOWN = 2'd1,
    LANE_1_UP   = 2'd2,
    LANE_1_DOWN = 2'd3
  } lane_e;

  function automatic int unsigned idx_w(input int unsigned n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/fft_pingpong_bank.sv
// Two-bank frame store: one 4-lane write port, one single-lane read port.
module fft_pingpong_bank
  import fft_out_serializer_pkg::*;
#(
  parameter int unsigned W     = 42,
  parameter int unsigned DEPTH = FFT_N / FFT_LANES,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic                        clk,
  input  logic                        wr_en,
  input  logic                        wr_bank,
  input  logic [AW-1:0]               wr_addr,
  input  logic [FFT_LANES-1:0][W-1:0] wr_data,
  input  logic                        rd_bank,
  input  logic [AW-1:0]               rd_addr,
  input  lane_e                       rd_lane,
  output logic [W-1:0]                rd_data
);

  logic [FFT_LANES-1:0][W-1:0] mem [2][DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_bank][wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_bank][rd_addr][rd_lane];

endmodule

// File: rtl/fft_out_serializer.sv
// Converts 4-lane FFT output beats into a serial, in-order complex sample stream
// through a ping-pong frame buffer.
module fft_out_serializer
  import fft_out_serializer_pkg::*;
#(
  parameter int unsigned NBITS_out = 21,
  parameter int unsigned N         = FFT_N
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NBITS_out*2-1:0] fftIn0_up,
  input  logic [NBITS_out*2-1:0] fftIn0_down,
  input  logic [NBITS_out*2-1:0] fftIn1_up,
  input  logic [NBITS_out*2-1:0] fftIn1_down,
  input  logic                   in_valid,
  input  logic                   in_sof,
  output logic                   in_ready,
  output logic [NBITS_out*2-1:0] out_data,
  output logic [$clog2(N)-1:0]   out_index,
  output logic                   out_valid,
  output logic                   out_last,
  input  logic                   out_ready,
  output logic                   err_sof
);

  localparam int unsigned W     = 2 * NBITS_out;
  localparam int unsigned BEATS = N / FFT_LANES;
  localparam int unsigned PTR_W = $clog2(BEATS);
  localparam int unsigned IDX_W = idx_w(N);

  logic [PTR_W-1:0] wr_ptr;
  logic [IDX_W-1:0] rd_idx;
  logic             wr_bank;
  logic             rd_bank;
  logic [1:0]       full;
  logic [1:0]       full_nxt;

  logic             accept;
  logic             restart;
  logic             fill;
  logic             xfer;
  logic             release_bank;
  logic [PTR_W-1:0] wr_addr;
  logic [W-1:0]     rd_data;
  logic [FFT_LANES-1:0][W-1:0] wr_data;

  assign in_ready     = ~full[wr_bank];
  assign out_valid    = full[rd_bank];
  assign accept       = in_valid & in_ready;
  assign restart      = in_sof & (wr_ptr != '0);
  assign fill         = accept & ~restart & (wr_ptr == PTR_W'(BEATS - 1));
  assign xfer         = out_valid & out_ready;
  assign release_bank = xfer & (rd_idx == IDX_W'(N - 1));
  assign wr_addr      = restart ? '0 : wr_ptr;
  assign wr_data      = {fftIn1_down, fftIn1_up, fftIn0_down, fftIn0_up};

  // Fill always targets the empty bank and release the full one, so the two
  // updates never touch the same flag.
  always_comb begin
    full_nxt = full;
    if (fill)         full_nxt[wr_bank] = 1'b1;
    if (release_bank) full_nxt[rd_bank] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_idx  <= '0;
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      full    <= '0;
      err_sof <= 1'b0;
    end else begin
      if (accept) begin
        if (restart) begin
          wr_ptr  <= PTR_W'(1);
          err_sof <= 1'b1;
        end else if (fill) begin
          wr_ptr  <= '0;
          wr_bank <= ~wr_bank;
        end else begin
          wr_ptr <= wr_ptr + 1'b1;
        end
      end
      if (xfer) begin
        if (release_bank) begin
          rd_idx  <= '0;
          rd_bank <= ~rd_bank;
        end else begin
          rd_idx <= rd_idx + 1'b1;
        end
      end
      full <= full_nxt;
    end
  end

  fft_pingpong_bank #(
    .W     (W),
    .DEPTH (BEATS),
    .AW    (PTR_W)
  ) u_bank (
    .clk     (clk),
    .wr_en   (accept),
    .wr_bank (wr_bank),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_bank (rd_bank),
    .rd_addr (rd_idx[IDX_W-1:2]),
    .rd_lane (lane_e'(rd_idx[1:0])),
    .rd_data (rd_data)
  );

  assign out_data  = out_valid ? rd_data : '0;
  assign out_index = out_valid ? rd_idx : '0;
  assign out_last  = out_valid & (rd_idx == IDX_W'(N - 1));

endmodule

// File: tb/tb_fft_out_serializer.sv
// Bench for fft_out_serializer: directed table, then frame-level scenarios checked
// against a queue model of frames in flight.
module tb_fft_out_serializer;
  import fft_out_serializer_pkg::*;

  localparam int unsigned NB    = 21;
  localparam int unsigned W     = 2 * NB;
  localparam int unsigned N     = 128;
  localparam int unsigned BEATS = N / 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] fftIn0_up = '0, fftIn0_down = '0, fftIn1_up = '0, fftIn1_down = '0;
  logic         in_valid = 1'b0, in_sof = 1'b0, out_ready = 1'b0;
  logic         in_ready, out_valid, out_last, err_sof;
  logic [W-1:0] out_data;
  logic [6:0]   out_index;

  always #5 clk = ~clk;

  fft_out_serializer #(.NBITS_out(NB), .N(N)) dut (
    .clk(clk), .rst(rst),
    .fftIn0_up(fftIn0_up), .fftIn0_down(fftIn0_down),
    .fftIn1_up(fftIn1_up), .fftIn1_down(fftIn1_down),
    .in_valid(in_valid), .in_sof(in_sof), .in_ready(in_ready),
    .out_data(out_data), .out_index(out_index), .out_valid(out_valid),
    .out_last(out_last), .out_ready(out_ready), .err_sof(err_sof)
  );

  typedef struct { logic sof; logic [3:0][W-1:0] d; } beat_t;
  typedef struct { logic [W-1:0] data; int unsigned idx; } samp_t;
  typedef struct {
    logic rst, vld, sof; int unsigned beat;
    logic e_ready, e_valid, e_err;
  } vec_t;

  int unsigned n_chk = 0, n_fail = 0;
  beat_t src_q[$];   // beats the source still has to deliver
  beat_t part_q[$];  // model: beats of the frame being assembled
  samp_t exp_q[$];   // model: samples owed downstream, in order
  logic  m_err = 1'b0;
  bit    gate = 1'b1, saw_block = 1'b0;
  int unsigned frames_out = 0, run_len = 0, max_run = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic drive_lanes(input logic [3:0][W-1:0] d);
    fftIn0_up = d[0]; fftIn0_down = d[1]; fftIn1_up = d[2]; fftIn1_down = d[3];
  endtask

  function automatic logic [3:0][W-1:0] idx_lanes(input int unsigned b);
    logic [3:0][W-1:0] d;
    for (int unsigned l = 0; l < 4; l++) d[l] = W'(4 * b + l);
    return d;
  endfunction

  function automatic logic [W-1:0] rnd_w();
    return W'({$urandom(), $urandom()});
  endfunction

  task automatic add_beats(input int unsigned nb, input bit rnd, input bit sof);
    beat_t x;
    for (int unsigned b = 0; b < nb; b++) begin
      x.sof = sof && (b == 0);
      for (int unsigned l = 0; l < 4; l++) x.d[l] = rnd ? rnd_w() : W'(4 * b + l);
      src_q.push_back(x);
    end
  endtask

  task automatic model_accept(input beat_t b);
    samp_t s;
    if (b.sof && part_q.size() != 0) begin
      part_q.delete();
      m_err = 1'b1;
    end
    part_q.push_back(b);
    if (part_q.size() == BEATS) begin
      for (int unsigned bb = 0; bb < BEATS; bb++)
        for (int unsigned l = 0; l < 4; l++) begin
          s.data = part_q[bb].d[l];
          s.idx  = 4 * bb + l;
          exp_q.push_back(s);
        end
      part_q.delete();
    end
  endtask

  task automatic tick(input int unsigned vp, input int unsigned rp);
    logic  acc, xfer, m_ready;
    beat_t b;
    logic [3:0][W-1:0] junk;
    m_ready  = ((exp_q.size() + N - 1) / N) < 2;
    in_valid = gate && (src_q.size() != 0) && ($urandom_range(99) < vp);
    if (in_valid) begin
      b = src_q[0];
      in_sof = b.sof;
      drive_lanes(b.d);
    end else begin
      for (int unsigned l = 0; l < 4; l++) junk[l] = rnd_w();
      in_sof = 1'($urandom_range(1));
      drive_lanes(junk);
    end
    out_ready = ($urandom_range(99) < rp);
    chk("in_ready", in_ready, m_ready);
    chk("out_valid", out_valid, exp_q.size() != 0);
    if (exp_q.size() != 0) begin
      chk("out_data", out_data, exp_q[0].data);
      chk("out_index", out_index, exp_q[0].idx);
      chk("out_last", out_last, exp_q[0].idx == N - 1);
    end else begin
      chk("idle_data", out_data, 0);
      chk("idle_index", out_index, 0);
      chk("idle_last", out_last, 0);
    end
    chk("err_sof", err_sof, m_err);
    if (in_valid && !in_ready) saw_block = 1'b1;
    run_len = out_valid ? run_len + 1 : 0;
    if (run_len > max_run) max_run = run_len;
    acc  = in_valid && m_ready;
    xfer = (exp_q.size() != 0) && out_ready;
    @(posedge clk); #1;
    if (xfer) begin
      if (exp_q[0].idx == N - 1) frames_out++;
      exp_q.delete(0);
    end
    if (acc) begin
      src_q.delete(0);
      model_accept(b);
    end
  endtask

  task automatic run_until_idle(input int unsigned max, input int unsigned vp, input int unsigned rp);
    int unsigned c = 0;
    while ((src_q.size() != 0 || exp_q.size() != 0) && c < max) begin
      tick(vp, rp);
      c++;
    end
    chk("drained", (src_q.size() == 0) && (exp_q.size() == 0), 1);
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; in_sof = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete(); part_q.delete(); src_q.delete();
    m_err = 1'b0; frames_out = 0; run_len = 0; max_run = 0; saw_block = 1'b0; gate = 1'b1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_err_sof", err_sof, 0);
    chk("rst_out_data", out_data, 0);
  endtask

  function automatic vec_t mkv(input logic r, v, s, input int unsigned b,
                               input logic er, ev, ee);
    vec_t t;
    t.rst = r; t.vld = v; t.sof = s; t.beat = b;
    t.e_ready = er; t.e_valid = ev; t.e_err = ee;
    return t;
  endfunction

  initial begin
    vec_t tbl[10];
    int unsigned c;
    tbl[0] = mkv(1, 0, 0, 0, 1, 0, 0);
    tbl[1] = mkv(0, 1, 1, 0, 1, 0, 0);
    tbl[2] = mkv(0, 1, 0, 1, 1, 0, 0);
    tbl[3] = mkv(0, 1, 0, 2, 1, 0, 0);
    tbl[4] = mkv(0, 1, 1, 0, 1, 0, 1);
    tbl[5] = mkv(0, 1, 0, 1, 1, 0, 1);
    tbl[6] = mkv(0, 0, 0, 0, 1, 0, 1);
    tbl[7] = mkv(1, 0, 0, 0, 1, 0, 0);
    tbl[8] = mkv(0, 1, 0, 0, 1, 0, 0);
    tbl[9] = mkv(1, 0, 0, 0, 1, 0, 0);
    for (int unsigned i = 0; i < 10; i++) begin
      rst = tbl[i].rst; in_valid = tbl[i].vld; in_sof = tbl[i].sof; out_ready = 1'b1;
      drive_lanes(idx_lanes(tbl[i].beat));
      @(posedge clk); #1;
      chk("tbl_in_ready", in_ready, tbl[i].e_ready);
      chk("tbl_out_valid", out_valid, tbl[i].e_valid);
      chk("tbl_err_sof", err_sof, tbl[i].e_err);
      chk("tbl_out_data", out_data, 0);
    end

    // One frame, data equal to index.
    do_reset();
    add_beats(BEATS, 0, 1);
    run_until_idle(400, 100, 100);
    chk("f1_frames", frames_out, 1);

    // Three back-to-back frames: backpressure and continuous output.
    do_reset();
    add_beats(BEATS, 1, 1); add_beats(BEATS, 1, 1); add_beats(BEATS, 1, 0);
    run_until_idle(900, 100, 100);
    chk("b2b_frames", frames_out, 3);
    chk("b2b_continuous", max_run, 3 * N);
    chk("b2b_blocked", saw_block, 1);

    // Random valid and 50% out_ready.
    do_reset();
    for (int unsigned f = 0; f < 4; f++) add_beats(BEATS, 1, f[0]);
    run_until_idle(4000, 60, 50);
    chk("rnd_frames", frames_out, 4);

    // Restart at beat 10 drops the partial frame.
    do_reset();
    add_beats(10, 1, 1);
    add_beats(BEATS, 1, 1);
    run_until_idle(1000, 80, 80);
    chk("sof_err", err_sof, 1);
    chk("sof_frames", frames_out, 1);

    // Reset while presenting index 50.
    do_reset();
    add_beats(BEATS, 1, 1); add_beats(BEATS, 1, 1);
    c = 0;
    while (!(exp_q.size() != 0 && exp_q[0].idx == 50) && c < 500) begin
      tick(100, 100);
      c++;
    end
    chk("mid_idx50", out_index, 50);
    do_reset();
    add_beats(BEATS, 1, 1);
    run_until_idle(400, 100, 100);
    chk("mid_frames", frames_out, 1);

    // Final beat of frame B accepted on the edge that consumes sample 127 of frame A.
    do_reset();
    add_beats(BEATS, 1, 1); add_beats(BEATS, 1, 1);
    c = 0;
    while (src_q.size() > 1 && c < 200) begin tick(100, 100); c++; end
    gate = 1'b0;
    c = 0;
    while (exp_q.size() != 1 && c < 400) begin tick(100, 100); c++; end
    gate = 1'b1;
    chk("coin_out_last", out_last, 1);
    chk("coin_in_ready", in_ready, 1);
    tick(100, 100);
    chk("coin_src_empty", src_q.size(), 0);
    run_until_idle(400, 100, 100);
    chk("coin_frames", frames_out, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/fft_out_serializer.md
FFT_OUT_SERIALIZER -- requirements
Module: fft_out_serializer

Interface
REQ-001 Parameter NBITS_out, default 21: width of each real and each imaginary component.
REQ-002 Parameter N, default 128: FFT frame length in complex samples; the frame is N/4 input beats of 4 lanes each.
REQ-003 clk  input  1  single clock; all logic is sampled on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 fftIn0_up, fftIn0_down, fftIn1_up, fftIn1_down  input  NBITS_out*2 each  lane samples from the final FFT stage; imaginary part in the upper half, real part in the lower half.
REQ-006 in_valid  input  1  the 4 lane inputs hold a beat.
REQ-007 in_sof  input  1  marks beat 0 of a frame; qualified by in_valid.
REQ-008 in_ready  output  1  the block can accept a beat this cycle.
REQ-009 out_data  output  NBITS_out*2  serial complex sample, same packing as the inputs.
REQ-010 out_index  output  $clog2(N)  sample index 0..N-1 within the frame.
REQ-011 out_valid  output  1  out_data, out_index and out_last are valid.
REQ-012 out_last  output  1  high with index N-1.
REQ-013 out_ready  input  1  downstream accepts the sample.
REQ-014 err_sof  output  1  sticky framing-error flag.

Function
REQ-015 The block shall hold two banks (ping-pong); each bank shall store N/4 beats x 4 lanes.
REQ-016 A beat shall be accepted when in_valid and in_ready are both high; it shall be written to the write bank at wr_ptr, and wr_ptr shall then increment.
REQ-017 in_ready shall be high whenever the current write bank is not marked full, and low when both banks are full.
REQ-018 Acceptance of the beat at wr_ptr = N/4-1 shall mark the write bank full, reset wr_ptr to 0, and toggle the write bank.
REQ-019 An accepted beat with in_sof high and wr_ptr != 0 shall drop the partial frame, be written as beat 0 (wr_ptr = 1 afterwards), and set err_sof.
REQ-020 An accepted beat with in_sof low and wr_ptr = 0 shall be accepted normally (in_sof is optional at frame start).
REQ-021 out_valid shall be high exactly while the read bank is marked full.
REQ-022 Output order within a beat b shall be 0_up, 0_down, 1_up, 1_down, giving out_index = 4b+lane.
REQ-023 A sample shall be transferred when out_valid and out_ready are both high; rd_idx shall then increment.
REQ-024 The transfer at rd_idx = N-1 (out_last high) shall clear the bank's full flag, reset rd_idx to 0, and toggle the read bank.
REQ-025 Latency: out_valid shall rise in the cycle after the edge that accepted the frame's last beat.
REQ-026 While out_valid is high and out_ready is low, out_data, out_index and out_last shall hold stable.
REQ-027 When out_valid is low, out_data, out_index and out_last shall be 0.
REQ-028 A bank release and a bank fill in the same cycle shall both take effect; no frame shall be lost or duplicated.
REQ-029 The sustained rate shall be 1 output sample per cycle; input beats shall be accepted at no more than 1 per 4 cycles on average.
REQ-030 Data shall pass through bit-exact; the block shall perform no arithmetic on sample values.

Reset
REQ-031 While rst is high, the following shall be forced at the next edge: wr_ptr=0, rd_idx=0, both bank-select registers=0, both full flags=0, err_sof=0, out_valid=0, in_ready=1.
REQ-032 Bank storage shall not be reset.
REQ-033 Reset asserted mid-frame shall discard all buffered and partial frames.

Structure
REQ-034 N, the lane count (4) and the index width shall be defined in the shared fft package used by the other FFT stages.
REQ-035 The storage shall be a single sub-module, fft_pingpong_bank, with one write port (4 lanes wide) and one read port (1 lane, mux by rd_idx); all control shall stay in fft_out_serializer.

Verification
REQ-036 Reset, then 32 beats with lane value = 4b+lane and out_ready=1 -> 128 outputs with data = index = 0..127, out_last only at 127, out_valid rising 1 cycle after beat 31.
REQ-037 Three back-to-back frames with out_ready=1 -> in_ready drops after 2 frames are buffered, no sample is lost, and output is continuous 384 samples.
REQ-038 out_ready toggling randomly at 50% -> order and values are unchanged and out_data is stable during stalls.
REQ-039 in_sof at beat 10 of a frame -> err_sof=1, the following 32 beats are output as one clean frame, and the partial frame is never output.
REQ-040 rst pulsed for 1 cycle at output index 50 -> next cycle out_valid=0 and in_ready=1; the next full frame is output from index 0.
REQ-041 Final frame beat accepted in the same cycle that the read bank's sample 127 is consumed -> both banks are handled correctly and the frame is output once.
